// File: rtl/fu_br_multi.sv
// N-lane EX-stage branch resolution: per-lane Branch outcome, oldest-mispredict
// redirect with a one-shot guard under stall, and a buffered predictor-update FIFO.

module fu_br_branch #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      br_type_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            br_o,
    output logic [XLEN-1:0] pc_br_o
);
    localparam logic [3:0] BEQ  = 4'd1, BNE  = 4'd2, BLT  = 4'd3, BGE = 4'd4,
                           BLTU = 4'd5, BGEU = 4'd6, JAL  = 4'd7, JALR = 4'd8;

    logic            take;
    logic [XLEN-1:0] tgt;

    // pc_br is the actual next PC: target when taken, fall-through otherwise
    always_comb begin
        take = 1'b0;
        tgt  = pc_i + imm_i;
        case (br_type_i)
            BEQ:  take = (rs1_i == rs2_i);
            BNE:  take = (rs1_i != rs2_i);
            BLT:  take = ($signed(rs1_i) <  $signed(rs2_i));
            BGE:  take = ($signed(rs1_i) >= $signed(rs2_i));
            BLTU: take = (rs1_i <  rs2_i);
            BGEU: take = (rs1_i >= rs2_i);
            JAL:  take = 1'b1;
            JALR: begin
                take = 1'b1;
                tgt  = (rs1_i + imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            default: take = 1'b0;
        endcase
        br_o    = take;
        pc_br_o = take ? tgt : pc_i + XLEN'(4);
    end
endmodule

module fu_br_multi #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int UPD_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_LANES-1:0]                ex_valid,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      ex_pc,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      ex_rdata1,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      ex_rdata2,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      ex_imm,
    input  logic [NUM_LANES-1:0][3:0]           ex_br_type,
    input  logic [NUM_LANES-1:0][1:0]           ex_pd_type,
    input  logic [NUM_LANES-1:0]                ex_br_pd,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      ex_pc_pd,
    input  logic                                stall_in,
    input  logic                                flush_in,
    output logic                                redirect,
    output logic [XLEN-1:0]                     redirect_pc,
    output logic [$clog2(NUM_LANES)-1:0]        redirect_lane,
    output logic                                upd_stall,
    output logic                                upd_valid,
    input  logic                                upd_ready,
    output logic [XLEN-1:0]                     upd_pc,
    output logic [1:0]                          upd_type,
    output logic [XLEN-1:0]                     upd_target,
    output logic                                upd_jump,
    output logic [$clog2(UPD_DEPTH):0]          upd_count
);
    localparam int LW = $clog2(NUM_LANES);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [1:0]      typ;
        logic [XLEN-1:0] target;
        logic            jump;
    } upd_t;

    logic [NUM_LANES-1:0]           br, m, trk;
    logic [NUM_LANES-1:0][XLEN-1:0] pc_br, fix_pc;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fu_br_branch #(.XLEN(XLEN)) u_br (
            .br_type_i (ex_br_type[i]),
            .pc_i      (ex_pc[i]),
            .rs1_i     (ex_rdata1[i]),
            .rs2_i     (ex_rdata2[i]),
            .imm_i     (ex_imm[i]),
            .br_o      (br[i]),
            .pc_br_o   (pc_br[i])
        );
        assign m[i]      = ex_valid[i] & (|ex_br_type[i]) &
                           ((ex_br_pd[i] ^ br[i]) | (ex_pc_pd[i] != pc_br[i]));
        assign fix_pc[i] = br[i] ? pc_br[i] : ex_pc[i] + XLEN'(4);
        assign trk[i]    = ex_valid[i] & (|ex_pd_type[i]);
    end

    logic            any_m, cand;
    logic [LW-1:0]   win;
    logic [XLEN-1:0] win_pc;
    upd_t            cand_e;

    // Descending scans so the lowest (oldest) lane wins; younger lanes than the
    // winning mispredict are squashed and cannot supply the update
    always_comb begin
        any_m  = 1'b0;
        win    = '0;
        win_pc = '0;
        for (int i = NUM_LANES-1; i >= 0; i--) begin
            if (m[i]) begin
                any_m  = 1'b1;
                win    = LW'(i);
                win_pc = fix_pc[i];
            end
        end
        cand   = 1'b0;
        cand_e = '0;
        for (int i = NUM_LANES-1; i >= 0; i--) begin
            if (trk[i] && (!any_m || i <= int'(win))) begin
                cand          = 1'b1;
                cand_e.pc     = ex_pc[i];
                cand_e.typ    = ex_pd_type[i];
                cand_e.target = pc_br[i];
                cand_e.jump   = br[i];
            end
        end
    end

    upd_t          mem_q [UPD_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          full, grp, eval, enq, deq;
    upd_t          head;

    assign full      = (cnt_q == CW'(UPD_DEPTH));
    assign grp       = rstn & (|ex_valid) & ~flush_in & ~done_q;
    assign upd_stall = grp & cand & full;
    assign eval      = grp & ~upd_stall;
    assign enq       = eval & cand & ~full;
    assign upd_valid = (cnt_q != '0);
    assign deq       = upd_valid & upd_ready;

    assign redirect      = eval & any_m;
    assign redirect_pc   = redirect ? win_pc : '0;
    assign redirect_lane = redirect ? win : '0;

    assign head       = upd_valid ? mem_q[rptr_q] : '0;
    assign upd_pc     = head.pc;
    assign upd_type   = head.typ;
    assign upd_target = head.target;
    assign upd_jump   = head.jump;
    assign upd_count  = cnt_q;

    // Guard holds while the same group is stalled; any unstalled cycle re-arms it
    always_comb begin
        done_d = done_q;
        if (!stall_in)
            done_d = 1'b0;
        else if (eval)
            done_d = 1'b1;
        cnt_d = cnt_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_q <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            done_q <= done_d;
            cnt_q  <= cnt_d;
            if (enq) begin
                mem_q[wptr_q] <= cand_e;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (deq) rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_fu_br_multi.sv
// Directed bench for fu_br_multi: redirect priority, stall guard, update FIFO flow.

module tb_fu_br_multi;
    localparam logic [3:0] BEQ = 4'd1, BNE = 4'd2, JAL = 4'd7, JALR = 4'd8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       ex_valid;
    logic [1:0][31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_pc_pd;
    logic [1:0][3:0]  ex_br_type;
    logic [1:0][1:0]  ex_pd_type;
    logic [1:0]       ex_br_pd;
    logic             stall_in, flush_in, upd_ready;
    logic             redirect, upd_stall, upd_valid, upd_jump;
    logic [31:0]      redirect_pc, upd_pc, upd_target;
    logic [0:0]       redirect_lane;
    logic [1:0]       upd_type;
    logic [2:0]       upd_count;

    int pass = 0;
    int chk  = 0;

    fu_br_multi #(.NUM_LANES(2), .XLEN(32), .UPD_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_br_type(ex_br_type), .ex_pd_type(ex_pd_type), .ex_br_pd(ex_br_pd),
        .ex_pc_pd(ex_pc_pd), .stall_in(stall_in), .flush_in(flush_in),
        .redirect(redirect), .redirect_pc(redirect_pc), .redirect_lane(redirect_lane),
        .upd_stall(upd_stall), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_type(upd_type), .upd_target(upd_target),
        .upd_jump(upd_jump), .upd_count(upd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic clear_lanes();
        ex_valid = '0; ex_pc = '0; ex_rdata1 = '0; ex_rdata2 = '0; ex_imm = '0;
        ex_br_type = '0; ex_pd_type = '0; ex_br_pd = '0; ex_pc_pd = '0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, r1, r2, imm,
                            input logic [3:0] bt, input logic [1:0] pt,
                            input logic bp, input logic [31:0] ppd);
        ex_valid[i] = 1'b1; ex_pc[i] = pc; ex_rdata1[i] = r1; ex_rdata2[i] = r2;
        ex_imm[i] = imm; ex_br_type[i] = bt; ex_pd_type[i] = pt;
        ex_br_pd[i] = bp; ex_pc_pd[i] = ppd;
    endtask

    task automatic drain();
        upd_ready = 1'b1;
        for (int k = 0; k < 16 && upd_count != 0; k++) @(negedge clk);
        upd_ready = 1'b0;
        #1;
        chk++; if (upd_count !== 3'd0) $display("FAIL drain_count got=%0d exp=0", upd_count); else pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall_in = 0; flush_in = 0; upd_ready = 0;
        clear_lanes();
        repeat (2) @(negedge clk);
        #1;
        chk++; if (redirect !== 1'b0) $display("FAIL rst_redirect got=%0h exp=0", redirect); else pass++;
        chk++; if (upd_valid !== 1'b0) $display("FAIL rst_upd_valid got=%0h exp=0", upd_valid); else pass++;
        chk++; if (upd_count !== 3'd0) $display("FAIL rst_upd_count got=%0d exp=0", upd_count); else pass++;
        chk++; if (upd_stall !== 1'b0) $display("FAIL rst_upd_stall got=%0h exp=0", upd_stall); else pass++;
        chk++; if (upd_pc !== 32'h0) $display("FAIL rst_upd_pc got=%0h exp=0", upd_pc); else pass++;
        rstn = 1'b1;
    endtask

    task automatic test_taken_mispredict();
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'h1000, 5, 5, 32'h40, BEQ, 2'b01, 1'b0, 32'h1004);
        #1;
        chk++; if (redirect !== 1'b1) $display("FAIL t1_redirect got=%0h exp=1", redirect); else pass++;
        chk++; if (redirect_pc !== 32'h1040) $display("FAIL t1_redirect_pc got=%0h exp=1040", redirect_pc); else pass++;
        chk++; if (redirect_lane !== 1'b0) $display("FAIL t1_lane got=%0d exp=0", redirect_lane); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (redirect !== 1'b0) $display("FAIL t1_redirect_pulse got=%0h exp=0", redirect); else pass++;
        chk++; if (upd_count !== 3'd1) $display("FAIL t1_count got=%0d exp=1", upd_count); else pass++;
        chk++; if (upd_valid !== 1'b1) $display("FAIL t1_upd_valid got=%0h exp=1", upd_valid); else pass++;
        chk++; if (upd_pc !== 32'h1000) $display("FAIL t1_upd_pc got=%0h exp=1000", upd_pc); else pass++;
        chk++; if (upd_type !== 2'b01) $display("FAIL t1_upd_type got=%0d exp=1", upd_type); else pass++;
        chk++; if (upd_target !== 32'h1040) $display("FAIL t1_upd_target got=%0h exp=1040", upd_target); else pass++;
        chk++; if (upd_jump !== 1'b1) $display("FAIL t1_upd_jump got=%0h exp=1", upd_jump); else pass++;
        drain();
        chk++; if (upd_valid !== 1'b0 || upd_pc !== 32'h0) $display("FAIL t1_empty_head valid=%0h pc=%0h exp 0/0", upd_valid, upd_pc); else pass++;
    endtask

    task automatic test_lane_priority();
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'h1000, 5, 5, 32'h40, BEQ, 2'b01, 1'b0, 32'h1004);
        set_lane(1, 32'h2004, 1, 2, 32'hFFC, BNE, 2'b10, 1'b0, 32'h2008);
        #1;
        chk++; if (redirect_lane !== 1'b0) $display("FAIL both_lane got=%0d exp=0", redirect_lane); else pass++;
        chk++; if (redirect_pc !== 32'h1040) $display("FAIL both_pc got=%0h exp=1040", redirect_pc); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd1) $display("FAIL both_count got=%0d exp=1", upd_count); else pass++;
        chk++; if (upd_pc !== 32'h1000) $display("FAIL both_upd_pc got=%0h exp=1000", upd_pc); else pass++;
        drain();
        // Lane 0 is a plain ALU op, so lane 1 wins and supplies the update
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'h2000, 0, 0, 0, 4'd0, 2'b00, 1'b0, 32'h0);
        set_lane(1, 32'h2004, 1, 2, 32'hFFC, BNE, 2'b10, 1'b0, 32'h2008);
        #1;
        chk++; if (redirect_lane !== 1'b1) $display("FAIL l1_lane got=%0d exp=1", redirect_lane); else pass++;
        chk++; if (redirect_pc !== 32'h3000) $display("FAIL l1_pc got=%0h exp=3000", redirect_pc); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_pc !== 32'h2004) $display("FAIL l1_upd_pc got=%0h exp=2004", upd_pc); else pass++;
        chk++; if (upd_type !== 2'b10) $display("FAIL l1_upd_type got=%0d exp=2", upd_type); else pass++;
        chk++; if (upd_target !== 32'h3000) $display("FAIL l1_upd_target got=%0h exp=3000", upd_target); else pass++;
        drain();
    endtask

    task automatic test_stall_guard();
        int nred = 0;
        @(negedge clk);
        clear_lanes();
        stall_in = 1'b1;
        set_lane(0, 32'h4000, 1, 2, 32'h10, BNE, 2'b01, 1'b0, 32'h4004);
        #1;
        chk++; if (redirect_pc !== 32'h4010) $display("FAIL stall_pc got=%0h exp=4010", redirect_pc); else pass++;
        if (redirect === 1'b1) nred++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (redirect === 1'b1) nred++;
        end
        @(negedge clk);
        stall_in = 1'b0;
        #1;
        if (redirect === 1'b1) nred++;
        chk++; if (nred != 1) $display("FAIL stall_redirects got=%0d exp=1", nred); else pass++;
        chk++; if (upd_count !== 3'd1) $display("FAIL stall_count got=%0d exp=1", upd_count); else pass++;
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'h4100, 3, 3, 32'h80, BEQ, 2'b01, 1'b0, 32'h4104);
        #1;
        chk++; if (redirect !== 1'b1) $display("FAIL stall_next_redirect got=%0h exp=1", redirect); else pass++;
        chk++; if (redirect_pc !== 32'h4180) $display("FAIL stall_next_pc got=%0h exp=4180", redirect_pc); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd2) $display("FAIL stall_next_count got=%0d exp=2", upd_count); else pass++;
        drain();
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp_pc [4] = '{32'h200, 32'h300, 32'h400, 32'h5000};
        upd_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            clear_lanes();
            set_lane(0, 32'(k * 256), 7, 7, 32'h8, BEQ, 2'b01, 1'b1, 32'(k * 256 + 8));
            #1;
            chk++; if (redirect !== 1'b0) $display("FAIL fill_redirect_%0d got=%0h exp=0", k, redirect); else pass++;
        end
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd4) $display("FAIL full_count got=%0d exp=4", upd_count); else pass++;
        chk++; if (upd_pc !== 32'h100 || upd_target !== 32'h108 || upd_jump !== 1'b1)
            $display("FAIL full_head pc=%0h tgt=%0h jump=%0h exp 100/108/1", upd_pc, upd_target, upd_jump); else pass++;
        @(negedge clk);
        set_lane(0, 32'h5000, 9, 9, 32'h20, BEQ, 2'b11, 1'b0, 32'h5004);
        #1;
        chk++; if (upd_stall !== 1'b1) $display("FAIL full_upd_stall got=%0h exp=1", upd_stall); else pass++;
        chk++; if (redirect !== 1'b0) $display("FAIL full_redirect got=%0h exp=0", redirect); else pass++;
        @(negedge clk);
        upd_ready = 1'b1;
        #1;
        chk++; if (upd_stall !== 1'b1 || redirect !== 1'b0)
            $display("FAIL full_ready_cycle stall=%0h redirect=%0h exp 1/0", upd_stall, redirect); else pass++;
        @(negedge clk);
        upd_ready = 1'b0;
        #1;
        chk++; if (upd_stall !== 1'b0) $display("FAIL retry_upd_stall got=%0h exp=0", upd_stall); else pass++;
        chk++; if (redirect !== 1'b1 || redirect_pc !== 32'h5020)
            $display("FAIL retry_redirect got=%0h pc=%0h exp 1/5020", redirect, redirect_pc); else pass++;
        chk++; if (upd_count !== 3'd3) $display("FAIL retry_count got=%0d exp=3", upd_count); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd4) $display("FAIL refill_count got=%0d exp=4", upd_count); else pass++;
        for (int j = 0; j < 4; j++) begin
            chk++; if (upd_pc !== exp_pc[j]) $display("FAIL wrap_head_%0d got=%0h exp=%0h", j, upd_pc, exp_pc[j]); else pass++;
            if (j == 3) begin
                chk++; if (upd_type !== 2'b11 || upd_target !== 32'h5020)
                    $display("FAIL wrap_tail type=%0d tgt=%0h exp 3/5020", upd_type, upd_target); else pass++;
            end
            upd_ready = 1'b1;
            @(negedge clk);
            upd_ready = 1'b0;
            #1;
        end
        chk++; if (upd_count !== 3'd0 || upd_valid !== 1'b0)
            $display("FAIL wrap_empty count=%0d valid=%0h exp 0/0", upd_count, upd_valid); else pass++;
    endtask

    task automatic test_correct_not_taken();
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'h6000, 4, 4, 32'h40, BNE, 2'b10, 1'b0, 32'h6004);
        #1;
        chk++; if (redirect !== 1'b0) $display("FAIL nt_redirect got=%0h exp=0", redirect); else pass++;
        @(negedge clk);
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd1 || upd_jump !== 1'b0)
            $display("FAIL nt_update count=%0d jump=%0h exp 1/0", upd_count, upd_jump); else pass++;
        drain();
    endtask

    task automatic test_boundary();
        @(negedge clk);
        clear_lanes();
        set_lane(0, 32'hFFFF_FFF0, 0, 0, 32'h20, JAL, 2'b01, 1'b0, 32'hFFFF_FFF4);
        #1;
        chk++; if (redirect_pc !== 32'h10) $display("FAIL wrap_pc got=%0h exp=10", redirect_pc); else pass++;
        @(negedge clk);
        clear_lanes();
        upd_ready = 1'b1;
        set_lane(0, 32'h2000, 32'h1001, 0, 32'h10, JALR, 2'b01, 1'b1, 32'h1011);
        #1;
        chk++; if (redirect !== 1'b1 || redirect_pc !== 32'h1010)
            $display("FAIL jalr_redirect got=%0h pc=%0h exp 1/1010", redirect, redirect_pc); else pass++;
        @(negedge clk);
        upd_ready = 1'b0;
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd1 || upd_pc !== 32'h2000)
            $display("FAIL enq_deq count=%0d head=%0h exp 1/2000", upd_count, upd_pc); else pass++;
        @(negedge clk);
        set_lane(0, 32'h7000, 0, 0, 0, 4'hF, 2'b00, 1'b1, 32'h7100);
        #1;
        chk++; if (redirect !== 1'b1 || redirect_pc !== 32'h7004)
            $display("FAIL unknown_type got=%0h pc=%0h exp 1/7004", redirect, redirect_pc); else pass++;
        @(negedge clk);
        clear_lanes();
        drain();
    endtask

    task automatic test_flush_reset();
        @(negedge clk);
        clear_lanes();
        flush_in = 1'b1;
        set_lane(0, 32'h1000, 5, 5, 32'h40, BEQ, 2'b01, 1'b0, 32'h1004);
        #1;
        chk++; if (redirect !== 1'b0 || upd_stall !== 1'b0)
            $display("FAIL flush_redirect got=%0h stall=%0h exp 0/0", redirect, upd_stall); else pass++;
        @(negedge clk);
        flush_in = 1'b0;
        clear_lanes();
        #1;
        chk++; if (upd_count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", upd_count); else pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            clear_lanes();
            set_lane(0, 32'h8000 + 32'(k * 16), 1, 1, 32'h8, BEQ, 2'b01, 1'b1, 32'h8008 + 32'(k * 16));
        end
        @(negedge clk);
        clear_lanes();
        stall_in = 1'b1;
        set_lane(0, 32'h9000, 1, 2, 32'h40, BNE, 2'b00, 1'b0, 32'h9004);
        #1;
        chk++; if (redirect !== 1'b1) $display("FAIL rs_first_redirect got=%0h exp=1", redirect); else pass++;
        @(negedge clk); #1;
        chk++; if (redirect !== 1'b0 || upd_count !== 3'd2)
            $display("FAIL rs_held redirect=%0h count=%0d exp 0/2", redirect, upd_count); else pass++;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk); #1;
        chk++; if (upd_valid !== 1'b0 || upd_count !== 3'd0 || redirect !== 1'b0)
            $display("FAIL rs_after valid=%0h count=%0d redirect=%0h exp 0/0/0", upd_valid, upd_count, redirect); else pass++;
        rstn = 1'b1;
        #1;
        chk++; if (redirect !== 1'b1) $display("FAIL rs_guard_cleared got=%0h exp=1", redirect); else pass++;
        @(negedge clk);
        stall_in = 1'b0;
        clear_lanes();
    endtask

    initial begin
        test_reset();
        test_taken_mispredict();
        test_lane_priority();
        test_stall_guard();
        test_fifo_full();
        test_correct_not_taken();
        test_boundary();
        test_flush_reset();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/fu_br_multi.md
Name: fu_br_multi

Overview:
- N-lane branch resolution unit for the EX stage. It generalises the fixed A/B dual-issue branch unit to NUM_LANES lanes.
- Per-lane outcome comes from one Branch instance per lane (br, pc_br).
- Adds an internal one-shot guard against repeated redirects under a held stall; the external stall-buffer signals are no longer needed.
- Adds a buffered predictor-update queue with a valid/ready handshake towards the branch predictor.

Parameters:
NUM_LANES, 2, issue lanes per EX group; lane 0 is oldest in program order
XLEN, 32, address/data width
UPD_DEPTH, 4, predictor-update FIFO entries; must be a power of 2, at least 2

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset, sampled on rising clk
ex_valid  in  NUM_LANES  lane holds a valid instruction
ex_pc  in  NUM_LANES*XLEN  lane PC
ex_rdata1  in  NUM_LANES*XLEN  first source operand
ex_rdata2  in  NUM_LANES*XLEN  second source operand
ex_imm  in  NUM_LANES*XLEN  immediate
ex_br_type  in  NUM_LANES*4  Branch type; 4'b0000 means not a branch
ex_pd_type  in  NUM_LANES*2  predictor class; 2'b00 means not tracked
ex_br_pd  in  NUM_LANES  predicted taken
ex_pc_pd  in  NUM_LANES*XLEN  predicted next PC
stall_in  in  1  EX group held this cycle (dcache/div/other)
flush_in  in  1  EX group squashed by a younger-stage flush
redirect  out  1  mispredict redirect pulse
redirect_pc  out  XLEN  corrected fetch PC
redirect_lane  out  $clog2(NUM_LANES)  lane that caused the redirect
upd_stall  out  1  update FIFO full; EX must hold
upd_valid  out  1  FIFO head valid
upd_ready  in  1  predictor accepts head
upd_pc  out  XLEN  head: branch PC
upd_type  out  2  head: pd_type
upd_target  out  XLEN  head: computed target
upd_jump  out  1  head: actual taken
upd_count  out  $clog2(UPD_DEPTH)+1  FIFO occupancy

Behaviour:
- Per-lane mispredict m[i] = ex_valid[i] & (br_type!=0) & ((br_pd ^ br) | (pc_pd != pc_br)).
- Per-lane fix PC = br ? pc_br : pc+4, in XLEN-bit arithmetic, wrapping modulo 2^XLEN.
- Winner: lowest index i with m[i]. Lanes above the winner are squashed and produce no update.
- Update candidate u: lowest lane with ex_valid & (pd_type!=0), considered only if u is not above the winner. At most one enqueue per group.
- done register: reset 0. eval = |ex_valid & ~flush_in & ~done & ~upd_stall.
  - done <= 1 when eval & stall_in.
  - done <= 0 whenever stall_in = 0.
  - A group held for k cycles therefore evaluates exactly once, on its first cycle.
- upd_stall = |ex_valid & ~flush_in & ~done & candidate_exists & full.
  - While upd_stall is high: no redirect, no enqueue, done unchanged.
  - Retry each cycle until the FIFO has space.
- redirect = eval & (|m), combinational in the evaluation cycle. redirect_pc and redirect_lane come from the winner. Both are 0 when redirect = 0.
- Enqueue on eval & candidate_exists & ~full. A full FIFO never enqueues, even if upd_ready is high in the same cycle.
- Dequeue when upd_valid & upd_ready. Head outputs are registered FIFO contents; they are 0 when empty. Simultaneous enqueue and dequeue when not full: upd_count is unchanged.
- Read/write pointers wrap modulo UPD_DEPTH.
- flush_in: the current group is not evaluated. FIFO contents and done are retained, and done still clears on ~stall_in.
- Reset (rstn = 0 at clk edge): FIFO empty, pointers 0, done = 0. All outputs are 0 in the following cycle. Reset mid-stall discards the guard and all queued updates.
- Unknown br_type values: whatever Branch returns is treated as a non-taken branch.

Test Plan:
- Lane0 BEQ, pc=0x1000, imm=0x40, rdata1=rdata2=5, br_pd=0 -> one-cycle redirect=1, redirect_pc=0x1040, lane=0; FIFO receives {0x1000, type, 0x1040, 1}.
- Both lanes mispredict (lane1 pc=0x2004 taken to 0x3000) -> redirect_lane=0 only; lane1 not enqueued; upd_count +1.
- Mispredicting group held by stall_in for 3 cycles -> redirect exactly once in cycle 1; stall_in drops, then a new group mispredicts -> redirect again.
- FIFO filled to 4 with upd_ready=0, then a new branch group -> upd_stall=1, no redirect. Raise upd_ready for one cycle -> the next cycle evaluates, redirect fires, upd_count returns to 4.
- flush_in=1 with a mispredicting lane -> redirect=0, no enqueue. Reset asserted mid-stall with 2 queued entries -> upd_valid=0, upd_count=0, redirect=0 next cycle.
- Correct prediction (br_pd=1, pc_pd=target) -> redirect=0, update still enqueued with jump=1.
